// File: rtl/dcnn_s1_ctrl.sv
// dcnn_s1_ctrl -- sequencer for one convolution layer on a PE chain.
//
// A job is a single pass through the phases below:
//   CFG    : request a chain configure and wait for the acknowledge
//            (bounded by a timeout)
//   KLOAD  : accept k_size*k_size kernel words
//   STREAM : accept m_size*m_size image pixel pairs, scanned row-major
//   DRAIN  : let the chain pipeline empty for DRAIN_CYC cycles
//   DONE   : pulse done for one cycle, then return to IDLE
//
// Ports
//   clk, arst_n          clock, asynchronous active-low reset
//   start                one-cycle job request (only honoured in IDLE)
//   k_size, m_size       kernel / image edge lengths, latched on start
//   para_num_in          parallel-output count, latched on start
//   para_out_num         latched para_num_in, held for the whole job
//   pe_chain_cfg         configure request (asserted while in CFG)
//   pe_chain_cfg_done    configure acknowledge
//   mode_kernel_load     chain is in kernel-load mode
//   kern_vld / kern_rdy  kernel word handshake
//   img_vld  / img_rdy   image pixel-pair handshake
//   busy                 job in progress (any state except IDLE)
//   done                 one-cycle job-complete pulse
//   err                  one-cycle pulse: zero-sized start or configure timeout
module dcnn_s1_ctrl #(
    parameter int K_BITS           = 4,
    parameter int M_BITS           = 10,
    parameter int MAX_PARA_OUT_BIT = 7,
    parameter int DRAIN_CYC        = 16,
    parameter int CFG_TMO          = 255
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        start,
    input  logic [K_BITS-1:0]           k_size,
    input  logic [M_BITS-1:0]           m_size,
    input  logic [MAX_PARA_OUT_BIT-1:0] para_num_in,
    output logic [MAX_PARA_OUT_BIT-1:0] para_out_num,
    output logic                        pe_chain_cfg,
    input  logic                        pe_chain_cfg_done,
    output logic                        mode_kernel_load,
    input  logic                        kern_vld,
    output logic                        kern_rdy,
    input  logic                        img_vld,
    output logic                        img_rdy,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_KLOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // The drain counter runs 0..DRAIN_CYC-1.
    localparam int              DRN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);
    localparam logic [7:0]       TMO_LAST = 8'(CFG_TMO - 1);

    state_t                      state_q, state_d;
    logic [K_BITS-1:0]           k_q, k_d;
    logic [M_BITS-1:0]           m_q, m_d;
    logic [MAX_PARA_OUT_BIT-1:0] para_q, para_d;
    logic [2*K_BITS-1:0]         kcnt_q, kcnt_d;
    logic [M_BITS-1:0]           col_q, col_d;
    logic [M_BITS-1:0]           row_q, row_d;
    logic [7:0]                  tmo_q, tmo_d;
    logic [DRN_W-1:0]            drn_q, drn_d;
    logic                        err_q, err_d;

    // Kernel word count; double width so 15*15 does not overflow.
    logic [2*K_BITS-1:0] k_sq;
    assign k_sq = {{K_BITS{1'b0}}, k_q} * {{K_BITS{1'b0}}, k_q};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            m_q     <= '0;
            para_q  <= '0;
            kcnt_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            tmo_q   <= '0;
            drn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m_q     <= m_d;
            para_q  <= para_d;
            kcnt_q  <= kcnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tmo_q   <= tmo_d;
            drn_q   <= drn_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        m_d     = m_q;
        para_d  = para_q;
        kcnt_d  = kcnt_q;
        col_d   = col_q;
        row_d   = row_q;
        tmo_d   = tmo_q;
        drn_d   = drn_q;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((k_size != '0) && (m_size != '0)) begin
                        k_d     = k_size;
                        m_d     = m_size;
                        para_d  = para_num_in;
                        tmo_d   = '0;
                        state_d = S_CFG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_CFG: begin
                // An acknowledge on the final allowed cycle still wins.
                if (pe_chain_cfg_done) begin
                    kcnt_d  = '0;
                    state_d = S_KLOAD;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            S_KLOAD: begin
                if (kern_vld) begin
                    if (kcnt_q == k_sq - 1'b1) begin
                        kcnt_d  = '0;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end

            S_STREAM: begin
                if (img_vld) begin
                    if (col_q == m_q - 1'b1) begin
                        col_d = '0;
                        if (row_q == m_q - 1'b1) begin
                            row_d   = '0;
                            drn_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    drn_d   = '0;
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decode directly from state, so they fall to zero
    // the moment reset forces IDLE.
    assign pe_chain_cfg     = (state_q == S_CFG);
    assign mode_kernel_load = (state_q == S_KLOAD);
    assign kern_rdy         = (state_q == S_KLOAD);
    assign img_rdy          = (state_q == S_STREAM);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign err              = err_q;
    assign para_out_num     = para_q;

endmodule

// File: tb/tb_dcnn_s1_ctrl.sv
module tb_dcnn_s1_ctrl;

    logic       clk;
    logic       arst_n;
    logic       start;
    logic [3:0] k_size;
    logic [9:0] m_size;
    logic [6:0] para_num_in;
    logic [6:0] para_out_num;
    logic       pe_chain_cfg;
    logic       pe_chain_cfg_done;
    logic       mode_kernel_load;
    logic       kern_vld;
    logic       kern_rdy;
    logic       img_vld;
    logic       img_rdy;
    logic       busy;
    logic       done;
    logic       err;

    dcnn_s1_ctrl dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .start             (start),
        .k_size            (k_size),
        .m_size            (m_size),
        .para_num_in       (para_num_in),
        .para_out_num      (para_out_num),
        .pe_chain_cfg      (pe_chain_cfg),
        .pe_chain_cfg_done (pe_chain_cfg_done),
        .mode_kernel_load  (mode_kernel_load),
        .kern_vld          (kern_vld),
        .kern_rdy          (kern_rdy),
        .img_vld           (img_vld),
        .img_rdy           (img_rdy),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected end-of-job event; cfg = cycles pe_chain_cfg was high,
    // drn = cycles spent draining. para < 0 means not checked.
    typedef struct {
        bit is_done;
        int kx;
        int ix;
        int cfg;
        int drn;
        int para;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   kx = 0, ix = 0, cfg_cyc = 0, drn_cyc = 0, para_bad = 0;
    bit   gap_mode = 1'b0;
    bit   cfg_auto = 1'b1;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic exp_t mk(bit d, int k, int i, int c, int r, int p);
        exp_t e;
        e.is_done = d; e.kx = k; e.ix = i; e.cfg = c; e.drn = r; e.para = p;
        return e;
    endfunction

    // Valid sources: always valid, or random gaps.
    initial begin
        kern_vld = 1'b0;
        img_vld  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            kern_vld = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            img_vld  = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Chain model: acknowledge on the second configure cycle.
    initial begin
        int n;
        n = 0;
        pe_chain_cfg_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pe_chain_cfg) begin
                pe_chain_cfg_done = cfg_auto && (n == 1);
                n++;
            end else begin
                pe_chain_cfg_done = 1'b0;
                n = 0;
            end
        end
    end

    // Monitor: tally transfers and phase lengths, compare at every done/err.
    always @(negedge clk) begin
        if (!arst_n) begin
            kx = 0; ix = 0; cfg_cyc = 0; drn_cyc = 0; para_bad = 0;
        end else begin
            if (kern_vld && kern_rdy) kx++;
            if (img_vld && img_rdy) ix++;
            if (pe_chain_cfg) cfg_cyc++;
            if (busy && !pe_chain_cfg && !kern_rdy && !img_rdy && !done) drn_cyc++;
            if (busy && q.size() > 0 && q[0].is_done && int'(para_out_num) != q[0].para)
                para_bad++;
            if (done || err) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got done=%0b err=%0b expected none", done, err);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event_is_done", int'(done), int'(e.is_done));
                    chk("event_is_err", int'(err), int'(!e.is_done));
                    chk("kern_xfers", kx, e.kx);
                    chk("img_xfers", ix, e.ix);
                    chk("cfg_cycles", cfg_cyc, e.cfg);
                    chk("drain_cycles", drn_cyc, e.drn);
                    if (e.is_done) begin
                        chk("para_out_num", int'(para_out_num), e.para);
                        chk("para_held", para_bad, 0);
                    end else begin
                        chk("busy_at_err", int'(busy), 0);
                    end
                end
                kx = 0; ix = 0; cfg_cyc = 0; drn_cyc = 0; para_bad = 0;
            end
        end
    end

    // One-cycle start; entered and left at posedge+1.
    task automatic issue(input int k, input int m, input int p);
        start       = 1'b1;
        k_size      = 4'(k);
        m_size      = 10'(m);
        para_num_in = 7'(p);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!busy && q.size() == 0) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout, busy=%0b pending=%0d expected idle with 0 pending", name, busy, q.size());
    endtask

    function automatic int outs();
        return int'({pe_chain_cfg, mode_kernel_load, kern_rdy, img_rdy, busy, done, err, para_out_num});
    endfunction

    initial begin
        arst_n      = 1'b0;
        start       = 1'b0;
        k_size      = '0;
        m_size      = '0;
        para_num_in = '0;
        #12;
        chk("reset_outputs", outs(), 0);

        // Job 1: k=3 m=4 para=8, start coincides with reset release.
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        q.push_back(mk(1'b1, 9, 16, 2, 16, 8));
        issue(3, 4, 8);
        chk("start_first_edge_busy", int'(busy), 1);
        chk("start_first_edge_cfg", int'(pe_chain_cfg), 1);
        wait_quiet("job1", 200);

        // Zero-size starts are rejected with an error pulse.
        q.push_back(mk(1'b0, 0, 0, 0, 0, -1));
        issue(0, 4, 5);
        chk("bad_start_busy", int'(busy), 0);
        wait_quiet("bad_k", 20);
        q.push_back(mk(1'b0, 0, 0, 0, 0, -1));
        issue(2, 0, 5);
        wait_quiet("bad_m", 20);

        // Configure acknowledge never arrives.
        cfg_auto = 1'b0;
        q.push_back(mk(1'b0, 0, 0, 255, 0, -1));
        issue(2, 2, 4);
        wait_quiet("cfg_timeout", 400);
        cfg_auto = 1'b1;

        // k=2 m=3 with random valid gaps.
        gap_mode = 1'b1;
        q.push_back(mk(1'b1, 4, 9, 2, 16, 6));
        issue(2, 3, 6);
        wait_quiet("gaps", 500);
        gap_mode = 1'b0;

        // Reset in the middle of STREAM, then a full clean job.
        issue(2, 4, 9);
        for (int i = 0; i < 100 && ix < 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_stream", int'(img_rdy), 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("midjob_reset_outputs", outs(), 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        q.push_back(mk(1'b1, 9, 16, 2, 16, 5));
        issue(3, 4, 5);
        wait_quiet("after_reset", 200);

        // Starts in KLOAD and on the DONE cycle are ignored; the next IDLE
        // cycle's start is taken (k=1 m=1 corner).
        q.push_back(mk(1'b1, 4, 4, 2, 16, 3));
        issue(2, 2, 3);
        for (int i = 0; i < 20 && !kern_rdy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("in_kload", int'(kern_rdy), 1);
        issue(3, 3, 7);
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        chk("on_done_cycle", int'(done), 1);
        q.push_back(mk(1'b1, 1, 1, 2, 16, 1));
        issue(3, 3, 7);
        issue(1, 1, 1);
        chk("restart_busy", int'(busy), 1);
        wait_quiet("ignore_starts", 200);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcnn_s1_ctrl.md
DCNN_S1_CTRL -- requirements
Module: dcnn_s1_ctrl

Interface
REQ-001 SHALL have parameter K_BITS, default 4, kernel-size field width.
REQ-002 SHALL have parameter M_BITS, default 10, image-size field width.
REQ-003 SHALL have parameter MAX_PARA_OUT_BIT, default 7, para_out_num width.
REQ-004 SHALL have parameter DRAIN_CYC, default 16, pipeline drain cycles after last pixel.
REQ-005 SHALL have parameter CFG_TMO, default 255, max cycles to wait for pe_chain_cfg_done.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 start  in  1  one-cycle request to run one layer.
REQ-009 k_size  in  K_BITS  kernel edge length, sampled on accepted start.
REQ-010 m_size  in  M_BITS  image edge length, sampled on accepted start.
REQ-011 para_num_in  in  MAX_PARA_OUT_BIT  parallel-output count, sampled on accepted start.
REQ-012 para_out_num  out  MAX_PARA_OUT_BIT  latched para_num_in, held for whole job.
REQ-013 pe_chain_cfg  out  1  chain configure request.
REQ-014 pe_chain_cfg_done  in  1  chain configure acknowledge.
REQ-015 mode_kernel_load  out  1  chain in kernel-load mode.
REQ-016 kern_vld / kern_rdy  in / out  1 / 1  kernel word handshake.
REQ-017 img_vld / img_rdy  in / out  1 / 1  image pixel-pair handshake.
REQ-018 busy  out  1  job in progress; done  out  1  one-cycle job-complete pulse; err  out  1  one-cycle error pulse.

Function
REQ-019 States: IDLE, CFG, KLOAD, STREAM, DRAIN, DONE; encoding free.
REQ-020 IDLE: start=1 with k_size!=0 and m_size!=0 latches k_size, m_size, para_num_in and moves to CFG next cycle.
REQ-021 IDLE: start=1 with k_size==0 or m_size==0 pulses err next cycle and stays in IDLE.
REQ-022 start outside IDLE is ignored; no queueing.
REQ-023 CFG: pe_chain_cfg=1; on pe_chain_cfg_done=1 go to KLOAD; pe_chain_cfg deasserts the cycle after done is seen.
REQ-024 CFG: 8-bit timeout counter, cleared on CFG entry; reaching CFG_TMO cycles without done pulses err and returns to IDLE.
REQ-025 KLOAD: mode_kernel_load=1, kern_rdy=1; transfer = kern_vld&kern_rdy; after exactly k_size*k_size transfers go to STREAM.
REQ-026 Kernel counter 2*K_BITS bits wide, no overflow for max k_size.
REQ-027 STREAM: img_rdy=1, mode_kernel_load=0; column counter 0..m_size-1 increments per transfer, wraps to 0 and increments row counter; transfer at row=m_size-1, col=m_size-1 moves to DRAIN.
REQ-028 DRAIN: img_rdy=0; wait exactly DRAIN_CYC cycles, then DONE.
REQ-029 DONE: done=1 for one cycle, return to IDLE.
REQ-030 busy=1 in every state except IDLE.
REQ-031 kern_rdy=0 outside KLOAD; img_rdy=0 outside STREAM; vld without rdy is not counted.
REQ-032 Stalls (vld=0) hold all counters; no timeout in KLOAD or STREAM.
REQ-033 k_size=1 or m_size=1: single transfer completes the phase.

Reset
REQ-034 arst_n=0 forces IDLE asynchronously regardless of state, mid-job included.
REQ-035 Reset values: pe_chain_cfg=0, mode_kernel_load=0, kern_rdy=0, img_rdy=0, busy=0, done=0, err=0, para_out_num=0, all counters 0.
REQ-036 After arst_n release, first start is accepted on the first rising edge.

Verification
REQ-037 k=3, m=4, para=8, done after 2 cycles, vld always 1 -> 9 kernel transfers, 16 image transfers, DRAIN 16 cycles, done pulse once, para_out_num=8 throughout.
REQ-038 start with k_size=0 -> err pulse 1 cycle, busy stays 0, pe_chain_cfg never asserts.
REQ-039 pe_chain_cfg_done held 0 -> err after 255 CFG cycles, return to IDLE, busy=0.
REQ-040 k=2, m=3, random vld gaps -> exactly 4 kernel and 9 image transfers counted, row/col wrap at 3.
REQ-041 arst_n pulsed mid-STREAM -> all outputs at reset values immediately; new start runs a full job correctly.
REQ-042 start repeated during KLOAD and on the DONE cycle -> ignored, single done pulse; start in following IDLE cycle accepted.
